// File: rtl/klp32_pkg.sv
// Shared types and constants for the klp32 front end.
package klp32_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HOLD = 3'd4
    } fetch_state_t;

    // Instruction addresses are always word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry holding register for a word that arrived while decode was stalled.
module fetch_buffer
    import klp32_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc;

    // Clear wins: a redirect must never let a captured word survive.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding memory request, stall buffer and redirect handling.
//  state | meaning
//  IDLE  | first cycle after reset, no request
//  REQ   | request driven at pc, waiting for grant
//  WAIT  | granted, waiting for read data
//  DROP  | granted but redirected, next read data is thrown away
//  HOLD  | word parked in buffer until decode accepts it
module fetch
    import klp32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_pc_sel,
    input  logic [31:0] i_pc_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_fetch_inst,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_pc_inc,
    output logic        o_fetch_valid
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_out_inst;
    logic [XLEN-1:0] r_out_pc;
    logic [XLEN-1:0] r_out_pc_inc;
    logic            r_out_valid;

    logic            w_load_rsp;
    logic            w_load_buf;
    logic            w_bubble;
    logic            w_buf_load;
    logic            w_buf_clear;
    logic            w_buf_valid;
    logic [XLEN-1:0] w_buf_inst;
    logic [XLEN-1:0] w_buf_pc;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (i_imem_gnt) w_state_nxt = i_pc_sel ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (i_imem_rvalid)
                    w_state_nxt = (i_pc_sel || !i_stall) ? S_REQ : S_HOLD;
                else if (i_pc_sel)
                    w_state_nxt = S_DROP;
            end
            S_DROP: begin
                if (i_imem_rvalid) w_state_nxt = S_REQ;
            end
            S_HOLD: begin
                if (i_pc_sel || !i_stall) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Redirect outranks everything; otherwise the slot only moves when decode accepts.
    always_comb begin
        w_pc_nxt   = r_pc;
        w_load_rsp = 1'b0;
        w_load_buf = 1'b0;
        if (i_pc_sel) begin
            w_pc_nxt = align_word(i_pc_target);
        end else if (r_state == S_WAIT && i_imem_rvalid && !i_stall) begin
            w_load_rsp = 1'b1;
            w_pc_nxt   = r_pc + 32'd4;
        end else if (r_state == S_HOLD && !i_stall && w_buf_valid) begin
            w_load_buf = 1'b1;
            w_pc_nxt   = r_pc + 32'd4;
        end
        w_bubble    = i_pc_sel || (!i_stall && !w_load_rsp && !w_load_buf);
        w_buf_load  = (r_state == S_WAIT) && i_imem_rvalid && i_stall && !i_pc_sel;
        w_buf_clear = i_pc_sel || w_load_buf;
    end

    assign o_imem_req  = (r_state == S_REQ);
    assign o_imem_addr = r_pc;

    fetch_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_inst  (i_imem_rdata),
        .i_pc    (r_pc),
        .o_valid (w_buf_valid),
        .o_inst  (w_buf_inst),
        .o_pc    (w_buf_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_out_inst   <= NOP_INST;
            r_out_pc     <= '0;
            r_out_pc_inc <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_load_rsp) begin
                r_out_inst   <= i_imem_rdata;
                r_out_pc     <= r_pc;
                r_out_pc_inc <= r_pc + 32'd4;
                r_out_valid  <= 1'b1;
            end else if (w_load_buf) begin
                r_out_inst   <= w_buf_inst;
                r_out_pc     <= w_buf_pc;
                r_out_pc_inc <= w_buf_pc + 32'd4;
                r_out_valid  <= 1'b1;
            end else if (w_bubble) begin
                r_out_inst   <= NOP_INST;
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign o_fetch_inst   = r_out_inst;
    assign o_fetch_pc     = r_out_pc;
    assign o_fetch_pc_inc = r_out_pc_inc;
    assign o_fetch_valid  = r_out_valid;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed vector table, hand sequences, and random traffic against a queue model.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, pc_sel, gnt, rvalid;
    logic [31:0] pc_target, rdata;
    logic        req, fvalid;
    logic [31:0] addr, finst, fpc, fpc_inc;

    logic        h_stall, h_pc_sel, h_gnt, h_rvalid;
    logic [31:0] h_pc_target, h_rdata;
    logic        h_req, h_fvalid;
    logic [31:0] h_addr, h_finst, h_fpc, h_fpc_inc;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .i_stall(stall), .i_pc_sel(pc_sel), .i_pc_target(pc_target),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt), .i_imem_rvalid(rvalid),
        .i_imem_rdata(rdata), .o_fetch_inst(finst), .o_fetch_pc(fpc),
        .o_fetch_pc_inc(fpc_inc), .o_fetch_valid(fvalid)
    );

    fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
        .clk(clk), .reset(reset), .i_stall(h_stall), .i_pc_sel(h_pc_sel), .i_pc_target(h_pc_target),
        .o_imem_req(h_req), .o_imem_addr(h_addr), .i_imem_gnt(h_gnt), .i_imem_rvalid(h_rvalid),
        .i_imem_rdata(h_rdata), .o_fetch_inst(h_finst), .o_fetch_pc(h_fpc),
        .o_fetch_pc_inc(h_fpc_inc), .o_fetch_valid(h_fvalid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic [31:0] e_inst, input logic [31:0] e_pc,
                           input logic [31:0] e_inc, input logic e_valid);
        chk({tag, ".req"},    {31'd0, req},    {31'd0, e_req});
        chk({tag, ".addr"},   addr,            e_addr);
        chk({tag, ".inst"},   finst,           e_inst);
        chk({tag, ".pc"},     fpc,             e_pc);
        chk({tag, ".pc_inc"}, fpc_inc,         e_inc);
        chk({tag, ".valid"},  {31'd0, fvalid}, {31'd0, e_valid});
    endtask

    task automatic idle_inputs();
        stall = 0; pc_sel = 0; pc_target = 0; gnt = 0; rvalid = 0; rdata = 0;
        h_stall = 0; h_pc_sel = 0; h_pc_target = 0; h_gnt = 0; h_rvalid = 0; h_rdata = 0;
    endtask

    // Leaves the bench at a falling edge in the first cycle after reset release.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    typedef struct {
        logic        stall, sel;
        logic [31:0] tgt;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr, e_inst, e_pc, e_inc;
        logic        e_valid;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic sl, input logic [31:0] t,
                                input logic g, input logic rv, input logic [31:0] rd,
                                input logic er, input logic [31:0] ea, input logic [31:0] ei,
                                input logic [31:0] ep, input logic [31:0] ec, input logic ev);
        vec_t v;
        v.stall = s; v.sel = sl; v.tgt = t; v.gnt = g; v.rv = rv; v.rdata = rd;
        v.e_req = er; v.e_addr = ea; v.e_inst = ei; v.e_pc = ep; v.e_inc = ec; v.e_valid = ev;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] inst; logic [31:0] pc; } word_t;
    logic [31:0] m_pc, m_inst, m_opc, m_opc_inc;
    logic        m_valid;
    bit          m_first, m_pend, m_discard;
    word_t       m_q[$];

    task automatic model_reset(input logic [31:0] rst_pc);
        m_pc = rst_pc; m_inst = NOP; m_opc = 0; m_opc_inc = 0; m_valid = 0;
        m_first = 1; m_pend = 0; m_discard = 0; m_q.delete();
    endtask

    task automatic model_step(input logic s, input logic sel, input logic [31:0] tgt,
                              input logic g, input logic rv, input logic [31:0] rd);
        bit    issue;
        word_t w;
        issue = !m_first && !m_pend && (m_q.size() == 0) && g;
        if (sel) begin
            m_inst = NOP; m_valid = 0;
            m_q.delete();
            m_pc = {tgt[31:2], 2'b00};
            if (m_pend) begin
                if (rv) begin m_pend = 0; m_discard = 0; end
                else m_discard = 1;
            end else if (issue) begin
                m_pend = 1; m_discard = 1;
            end
        end else begin
            if (m_pend && rv) begin
                if (!m_discard) begin w.inst = rd; w.pc = m_pc; m_q.push_back(w); end
                m_pend = 0; m_discard = 0;
            end
            if (!s) begin
                if (m_q.size() > 0) begin
                    w = m_q.pop_front();
                    m_inst = w.inst; m_opc = w.pc; m_opc_inc = w.pc + 32'd4; m_valid = 1;
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_inst = NOP; m_valid = 0;
                end
            end
            if (issue) begin m_pend = 1; m_discard = 0; end
        end
        m_first = 0;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    vec_t vt[$];

    initial begin
        bit          mem_busy;
        int          mem_cnt;
        logic [31:0] mem_addr, cur_addr;
        logic        cur_req;

        reset = 1;
        idle_inputs();

        // Directed table: cycle-by-cycle from reset release.
        vt.push_back(mk(0,0,0,          0,0,0,            0,32'h000,NOP,         32'h000,32'h000,0));
        vt.push_back(mk(0,0,0,          1,0,0,            1,32'h000,NOP,         32'h000,32'h000,0));
        vt.push_back(mk(0,0,0,          0,1,32'h00500513, 0,32'h000,NOP,         32'h000,32'h000,0));
        vt.push_back(mk(0,0,0,          1,0,0,            1,32'h004,32'h00500513,32'h000,32'h004,1));
        vt.push_back(mk(1,0,0,          0,1,32'h00A7B833, 0,32'h004,NOP,         32'h000,32'h004,0));
        vt.push_back(mk(1,0,0,          0,0,0,            0,32'h004,NOP,         32'h000,32'h004,0));
        vt.push_back(mk(1,0,0,          0,1,32'h0BADF00D, 0,32'h004,NOP,         32'h000,32'h004,0));
        vt.push_back(mk(0,0,0,          0,0,0,            0,32'h004,NOP,         32'h000,32'h004,0));
        vt.push_back(mk(0,0,0,          1,0,0,            1,32'h008,32'h00A7B833,32'h004,32'h008,1));
        vt.push_back(mk(0,1,32'h102,    0,0,0,            0,32'h008,NOP,         32'h004,32'h008,0));
        vt.push_back(mk(0,0,0,          0,1,32'hDEADBEEF, 0,32'h100,NOP,         32'h004,32'h008,0));
        vt.push_back(mk(0,0,0,          1,0,0,            1,32'h100,NOP,         32'h004,32'h008,0));
        vt.push_back(mk(1,1,32'h200,    0,1,32'h11111111, 0,32'h100,NOP,         32'h004,32'h008,0));
        vt.push_back(mk(0,0,0,          0,0,0,            1,32'h200,NOP,         32'h004,32'h008,0));
        vt.push_back(mk(0,0,0,          1,0,0,            1,32'h200,NOP,         32'h004,32'h008,0));
        vt.push_back(mk(0,0,0,          0,1,32'h22222222, 0,32'h200,NOP,         32'h004,32'h008,0));
        vt.push_back(mk(0,1,32'h33,     0,0,0,            1,32'h204,32'h22222222,32'h200,32'h204,1));
        vt.push_back(mk(0,0,0,          1,0,0,            1,32'h030,NOP,         32'h200,32'h204,0));
        vt.push_back(mk(0,0,0,          0,1,32'h33333333, 0,32'h030,NOP,         32'h200,32'h204,0));
        vt.push_back(mk(0,0,0,          0,0,0,            1,32'h034,32'h33333333,32'h030,32'h034,1));

        do_reset();
        foreach (vt[i]) begin
            stall = vt[i].stall; pc_sel = vt[i].sel; pc_target = vt[i].tgt;
            gnt = vt[i].gnt; rvalid = vt[i].rv; rdata = vt[i].rdata;
            #1;
            chk_out($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_inst,
                    vt[i].e_pc, vt[i].e_inc, vt[i].e_valid);
            @(negedge clk);
        end

        // Reset in WAIT with a stale response right after release.
        do_reset();
        gnt = 0; #1;
        chk_out("rstw.c0", 0, 32'h0, NOP, 0, 0, 0);
        @(negedge clk); gnt = 1; #1;
        chk_out("rstw.c1", 1, 32'h0, NOP, 0, 0, 0);
        @(negedge clk); gnt = 0; reset = 1;
        @(negedge clk); reset = 0; rvalid = 1; rdata = 32'hBAD0BAD0; #1;
        chk_out("rstw.idle", 0, 32'h0, NOP, 0, 0, 0);
        @(negedge clk); rvalid = 0; gnt = 1; #1;
        chk_out("rstw.req", 1, 32'h0, NOP, 0, 0, 0);
        @(negedge clk); gnt = 0; rvalid = 1; rdata = 32'h00000093; #1;
        chk_out("rstw.wait", 0, 32'h0, NOP, 0, 0, 0);
        @(negedge clk); rvalid = 0; #1;
        chk_out("rstw.out", 1, 32'h4, 32'h00000093, 32'h0, 32'h4, 1);

        // Wrap-around reset pc on the second instance.
        do_reset();
        h_gnt = 1; #1;
        chk("hi.c0.req",   {31'd0, h_req}, 32'd0);
        chk("hi.c0.addr",  h_addr, 32'hFFFF_FFFC);
        chk("hi.c0.valid", {31'd0, h_fvalid}, 32'd0);
        @(negedge clk); #1;
        chk("hi.c1.req",   {31'd0, h_req}, 32'd1);
        chk("hi.c1.addr",  h_addr, 32'hFFFF_FFFC);
        @(negedge clk); h_rvalid = 1; h_rdata = 32'h00100093;
        @(negedge clk); h_rvalid = 0; #1;
        chk("hi.out.inst",   h_finst,   32'h00100093);
        chk("hi.out.pc",     h_fpc,     32'hFFFF_FFFC);
        chk("hi.out.pc_inc", h_fpc_inc, 32'h0000_0000);
        chk("hi.out.valid",  {31'd0, h_fvalid}, 32'd1);
        chk("hi.next.addr",  h_addr,    32'h0000_0000);
        chk("hi.next.req",   {31'd0, h_req}, 32'd1);

        // Random traffic against the queue model.
        do_reset();
        model_reset(32'h0);
        mem_busy = 0; mem_cnt = 0; mem_addr = 0;
        for (int c = 0; c < 3000; c++) begin
            chk_out($sformatf("rnd%0d", c), !m_first && !m_pend && (m_q.size() == 0),
                    m_pc, m_inst, m_opc, m_opc_inc, m_valid);
            cur_req  = req;
            cur_addr = addr;
            stall  = ($urandom % 4) == 0;
            pc_sel = ($urandom % 10) == 0;
            pc_target = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            gnt = ($urandom % 3) != 0;
            if (mem_busy && mem_cnt == 0) begin
                rvalid = 1; rdata = mem_word(mem_addr);
            end else if (!mem_busy && ($urandom % 6) == 0) begin
                rvalid = 1; rdata = $urandom;
            end else begin
                rvalid = 0; rdata = $urandom;
            end
            @(posedge clk);
            model_step(stall, pc_sel, pc_target, gnt, rvalid, rdata);
            if (mem_busy && rvalid) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (cur_req && gnt) begin
                mem_busy = 1; mem_cnt = $urandom % 3; mem_addr = cur_addr;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  pipeline clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 i_stall  input  1  decode cannot accept; fetch outputs hold.
REQ-006 i_pc_sel  input  1  redirect taken (branch/jump resolved).
REQ-007 i_pc_target  input  32  redirect address; bits [1:0] ignored, forced 2'b00.
REQ-008 o_imem_req  output  1  instruction memory request.
REQ-009 o_imem_addr  output  32  request address, word aligned.
REQ-010 i_imem_gnt  input  1  request accepted this cycle (req&&gnt = handshake).
REQ-011 i_imem_rvalid  input  1  read data valid.
REQ-012 i_imem_rdata  input  32  instruction word.
REQ-013 o_fetch_inst  output  32  instruction to decode.
REQ-014 o_fetch_pc  output  32  address of o_fetch_inst.
REQ-015 o_fetch_pc_inc  output  32  o_fetch_pc + 4.
REQ-016 o_fetch_valid  output  1  output slot holds a real instruction (0 = bubble).

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DROP, HOLD; at most one outstanding memory request.
REQ-018 IDLE -> REQ unconditionally next cycle.
REQ-019 REQ: o_imem_req=1, o_imem_addr=pc; req&&gnt -> WAIT; address sampled by memory only on handshake.
REQ-020 WAIT: rvalid && !i_stall -> output slot loads {rdata, pc, pc+4, valid=1}, pc<=pc+4, -> REQ.
REQ-021 WAIT: rvalid && i_stall -> word captured in one-entry buffer, -> HOLD; no new request while in HOLD.
REQ-022 HOLD: !i_stall -> buffer moves to output slot, pc<=pc+4, -> REQ.
REQ-023 Output slot updates only when i_stall=0; with no new word available it loads a bubble (inst 32'h0000_0013, valid 0, pc/pc_inc unchanged).
REQ-024 Redirect (i_pc_sel=1) has priority over stall and response: output slot becomes bubble next cycle, buffer cleared, pc<={i_pc_target[31:2],2'b00}.
REQ-025 Redirect in REQ without gnt -> REQ with new address next cycle; redirect in REQ with gnt, or in WAIT without rvalid -> DROP.
REQ-026 Redirect in WAIT/DROP coincident with rvalid -> returned word discarded, -> REQ at target.
REQ-027 DROP: next rvalid discarded, -> REQ at current pc; further redirects in DROP only update pc.
REQ-028 rvalid in IDLE, REQ or HOLD is ignored.
REQ-029 pc arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-030 Minimum latency: handshake at cycle N, rvalid at N+1, o_fetch_* valid at N+2.

Reset
REQ-031 Reset: state IDLE, pc=RESET_PC, o_imem_req=0, o_imem_addr=RESET_PC, o_fetch_inst=32'h0000_0013, o_fetch_pc=0, o_fetch_pc_inc=0, o_fetch_valid=0, buffer empty.
REQ-032 Reset asserted mid-transaction abandons the outstanding request; a later stale rvalid is ignored per REQ-028.

Structure
REQ-033 Shared package klp32_pkg holds fetch_state_t enum, XLEN=32, NOP_INST=32'h0000_0013.
REQ-034 One sub-module fetch_buffer: single-entry {inst, pc} holding register with load/clear/valid.

Verification
REQ-035 Reset release, gnt=1 always, rvalid one cycle after grant, rdata=32'h00500513 -> addr 0 requested cycle 1; output {00500513, pc 0, pc_inc 4, valid 1}; next addr 4.
REQ-036 i_stall=1 for 3 cycles while rvalid arrives with 32'h00A7B833 -> outputs frozen, state HOLD, no req; stall drops -> output 00A7B833 at correct pc, next req issued.
REQ-037 Redirect to 32'h0000_0102 during WAIT -> response discarded (never on output), next request addr 32'h0000_0100, output bubble.
REQ-038 Redirect same cycle as rvalid with i_stall=1 -> bubble next cycle, valid 0, next req to target.
REQ-039 RESET_PC=32'hFFFF_FFFC -> first output pc FFFF_FFFC, pc_inc 0, second request addr 0.
REQ-040 Reset asserted in WAIT, stale rvalid one cycle after release -> ignored; first output is word at RESET_PC.
